seg7_frame_capture: RTL and testbench
=====================================

# seg7_frame_capture

Captures the digits of a multiplexed N-digit 7-segment display bus and turns them into a packed BCD word. Each digit pattern must be stable for a set number of cycles before it is accepted, and invalid patterns are flagged. Each completed frame is presented on a valid/ready output port. It sits between the display-scan pins of the unit under observation and the downstream logic, replacing the single-digit combinational segment-to-BCD encoder.

## Interface
- DIGITS, 4: number of multiplexed digits (1..8).
- STABLE_CYCLES, 3: consecutive identical samples required to accept a digit (≥1).
- SEG_ACTIVE_LOW, 0: 1 = seg_in is inverted before decoding.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg_in  input  7  segments {a,b,c,d,e,f,g}, a = MSB.
- dig_sel  input  DIGITS  digit strobe; bit i = digit i driven; valid only when exactly one-hot.
- bcd_out  output  4*DIGITS  digit i in bits [4i+3:4i]; 4'hF for an invalid pattern.
- digit_err  output  DIGITS  bit i = digit i held an invalid pattern in this frame.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts the frame when high together with out_valid.
- overrun  output  1  sticky: a frame was overwritten before it was accepted.
- overrun_clr  input  1  clears overrun.

## Operation
- Decode table after optional inversion:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8.
  - 1110011→9; 1111011 is also accepted as 9.
  - Any other pattern → 4'hF and an error.
- Sample qualification:
  - A sample is usable only if dig_sel is one-hot. Zero-hot or multi-hot resets the stability counter and latches nothing.
  - The stability counter increments while {dig_sel, seg_in} equals the previous cycle's sample. Any change reloads it to 1.
  - At count == STABLE_CYCLES, the digit is latched into the staging register slot for that digit and its captured bit is set. The latch happens once per dwell, and the counter saturates.
  - A repeat dwell on an already-captured digit in the same frame overwrites the staging value; the last accepted value wins.
- States:
  - CAPTURE → PRESENT when all captured bits are 1. On that transition, the staging values and error bits load into bcd_out/digit_err, out_valid is set, and the captured bits clear.
  - PRESENT → CAPTURE on out_valid && out_ready, which clears out_valid.
  - Capture continues while in PRESENT. If a new frame completes while out_valid is high and out_ready is low, the new frame replaces bcd_out/digit_err, out_valid stays high, and overrun is set.
  - If the handshake and a new frame completion occur in the same cycle, the new frame is loaded, out_valid stays high, and overrun is not set.
- overrun clears on overrun_clr. If a set event and overrun_clr occur in the same cycle, set wins.
- Reset, including mid-frame:
  - bcd_out = 0, digit_err = 0, out_valid = 0, overrun = 0.
  - Captured bits, staging register and stability counter are cleared; the state is CAPTURE.
  - A partial frame is discarded.

## Timing
- Sample registered at edge 0. The digit is latched at edge STABLE_CYCLES−1 after its first sample.
- When the final digit latches, out_valid and bcd_out update at the next edge. The minimum latency from the final digit's first sample to out_valid is STABLE_CYCLES edges.
- STABLE_CYCLES = 1: every usable sample is latched in the cycle it is registered.
- out_valid deasserts at the edge after a cycle with out_valid && out_ready, unless a new frame loads at that edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package:
  - the ten segment-code constants, the alternate-9 constant and the BCD_INVALID = 4'hF constant;
  - a state enum {CAPTURE, PRESENT};
  - a function returning the counter width as $clog2(STABLE_CYCLES+1).
- Sub-module seg7_to_bcd: combinational 7-bit → {valid, 4-bit BCD} lookup using the package constants.
- Top level: sample register, stability counter, one-hot check, staging array, captured bitmap, FSM and output registers.

## Test plan
- Clean scan, DIGITS=4, STABLE_CYCLES=3: show digits 1,2,3,4 for 4 cycles each on dig_sel 0001..1000 → out_valid rises with bcd_out=16'h4321 and digit_err=0.
- Invalid and alternate patterns: digit 2 = 0000001, digit 0 = 1111011 → bcd_out[11:8]=F, digit_err=0100, bcd_out[3:0]=9.
- Glitch rejection: hold a digit for only 2 cycles, and separately drive a multi-hot dig_sel 0011 for 5 cycles → nothing is latched and out_valid stays 0.
- Backpressure: out_ready=0 across two complete frames → overrun=1 and the second frame's value is shown. Then assert overrun_clr and out_ready → overrun=0 and out_valid drops on the next edge.
- Same-cycle handshake and frame completion → new value loaded, out_valid stays 1, overrun stays 0.
- Reset after 3 of 4 digits are captured, then a full scan of 5,6,7,8 → first output is 16'h8765. All outputs read 0 while rst_n is low.

Source files
------------

// File: rtl/seg7_frame_capture_pkg.sv
// Shared constants, state type and sizing helper for the 7-segment frame capture block.
package seg7_frame_capture_pkg;

  // Segment codes {a,b,c,d,e,f,g}, a = MSB, active-high after optional inversion.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_9_ALT = 7'b1111011;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic {
    StCapture,
    StPresent
  } state_e;

  // Wide enough to hold the saturated count value STABLE_CYCLES.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/seg7_frame_capture_to_bcd.sv
// Combinational segment pattern to BCD lookup; unknown patterns give BCD_INVALID.
module seg7_to_bcd
  import seg7_frame_capture_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] bcd_o
);

  always_comb begin
    valid_o = 1'b1;
    bcd_o   = BCD_INVALID;
    case (seg_i)
      SEG_0:            bcd_o = 4'd0;
      SEG_1:            bcd_o = 4'd1;
      SEG_2:            bcd_o = 4'd2;
      SEG_3:            bcd_o = 4'd3;
      SEG_4:            bcd_o = 4'd4;
      SEG_5:            bcd_o = 4'd5;
      SEG_6:            bcd_o = 4'd6;
      SEG_7:            bcd_o = 4'd7;
      SEG_8:            bcd_o = 4'd8;
      SEG_9, SEG_9_ALT: bcd_o = 4'd9;
      default: begin
        valid_o = 1'b0;
        bcd_o   = BCD_INVALID;
      end
    endcase
  end

endmodule

// File: rtl/seg7_frame_capture.sv
// Qualifies multiplexed 7-segment digit samples, assembles frames of BCD digits and
// presents each completed frame on a valid/ready port with sticky overrun.
module seg7_frame_capture
  import seg7_frame_capture_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned STABLE_CYCLES  = 3,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int unsigned     CntW   = cnt_width(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [6:0] seg_dec;
  logic       dec_valid;
  logic [3:0] dec_bcd;

  assign seg_dec = SEG_ACTIVE_LOW ? ~seg_in : seg_in;

  seg7_to_bcd u_dec (
    .seg_i   (seg_dec),
    .valid_o (dec_valid),
    .bcd_o   (dec_bcd)
  );

  // Sample qualification
  logic [DIGITS+6:0] sample_q, sample_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              onehot;
  logic              same;
  logic              latch;

  always_comb begin
    sample_d = {dig_sel, seg_in};
    onehot   = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
    same     = (sample_d == sample_q);
    if (!onehot) begin
      cnt_d = '0;
    end else if (!same) begin
      cnt_d = CntOne;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntOne;
    end else begin
      cnt_d = cnt_q;
    end
    // A saturated, unchanged dwell has already been latched.
    latch = onehot && (cnt_d == CntMax) && !(same && (cnt_q == CntMax));
  end

  // Staging and captured bitmap
  logic [DIGITS-1:0][3:0] stage_q, stage_d;
  logic [DIGITS-1:0]      stage_err_q, stage_err_d;
  logic [DIGITS-1:0]      captured_q, captured_d;
  logic                   frame_done;

  assign frame_done = &captured_q;

  always_comb begin
    stage_d     = stage_q;
    stage_err_d = stage_err_q;
    // Bits latched on the completion edge belong to the following frame.
    captured_d  = frame_done ? '0 : captured_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (latch && dig_sel[i]) begin
        stage_d[i]     = dec_bcd;
        stage_err_d[i] = ~dec_valid;
        captured_d[i]  = 1'b1;
      end
    end
  end

  // Presentation FSM
  state_e                 state_q, state_d;
  logic [DIGITS-1:0][3:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]      err_q, err_d;
  logic                   overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    err_d     = err_q;
    overrun_d = overrun_q;
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    unique case (state_q)
      StCapture: begin
        if (frame_done) begin
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (frame_done) begin
          if (!out_ready) begin
            overrun_d = 1'b1;
          end
        end else if (out_ready) begin
          state_d = StCapture;
        end
      end
      default: state_d = StCapture;
    endcase
    if (frame_done) begin
      bcd_d = stage_q;
      err_d = stage_err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= '0;
      cnt_q       <= '0;
      stage_q     <= '0;
      stage_err_q <= '0;
      captured_q  <= '0;
      state_q     <= StCapture;
      bcd_q       <= '0;
      err_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      sample_q    <= sample_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      stage_err_q <= stage_err_d;
      captured_q  <= captured_d;
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign digit_err = err_q;
  assign out_valid = (state_q == StPresent);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_frame_capture.sv
// Directed bench for seg7_frame_capture with DIGITS=4, STABLE_CYCLES=3, active-high segments.
module tb_seg7_frame_capture;

  localparam logic [6:0] S0 = 7'h7E;
  localparam logic [6:0] S1 = 7'h30;
  localparam logic [6:0] S2 = 7'h6D;
  localparam logic [6:0] S3 = 7'h79;
  localparam logic [6:0] S4 = 7'h33;
  localparam logic [6:0] S5 = 7'h5B;
  localparam logic [6:0] S6 = 7'h5F;
  localparam logic [6:0] S7 = 7'h70;
  localparam logic [6:0] S8 = 7'h7F;
  localparam logic [6:0] S9 = 7'h73;
  localparam logic [6:0] S9A = 7'h7B;
  localparam logic [6:0] SBAD = 7'h01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        overrun_clr;

  int checks = 0;
  int failures = 0;

  seg7_frame_capture #(
    .DIGITS         (4),
    .STABLE_CYCLES  (3),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .digit_err   (digit_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; holds the pattern across n rising edges.
  task automatic show(input logic [3:0] sel, input logic [6:0] seg, input int n);
    dig_sel = sel;
    seg_in  = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    show(4'b0001, s0, 4);
    show(4'b0010, s1, 4);
    show(4'b0100, s2, 4);
    show(4'b1000, s3, 4);
  endtask

  task automatic handshake();
    dig_sel   = 4'b0000;
    seg_in    = 7'h00;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    seg_in      = S1;
    dig_sel     = 4'b0001;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_err", 32'(digit_err), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);

    rst_n = 1'b1;
    show(4'b0000, 7'h00, 2);

    // Clean scan
    scan(S1, S2, S3, S4);
    chk("clean_valid", 32'(out_valid), 32'h1);
    chk("clean_bcd", 32'(bcd_out), 32'h4321);
    chk("clean_err", 32'(digit_err), 32'h0);
    chk("clean_overrun", 32'(overrun), 32'h0);
    handshake();
    chk("clean_hs_valid", 32'(out_valid), 32'h0);

    // Invalid and alternate-9 patterns
    scan(S9A, S1, SBAD, S4);
    chk("inv_valid", 32'(out_valid), 32'h1);
    chk("inv_bcd", 32'(bcd_out), 32'h4F19);
    chk("inv_err", 32'(digit_err), 32'b0100);
    handshake();
    chk("inv_hs_valid", 32'(out_valid), 32'h0);

    // Glitch rejection: short dwell then multi-hot strobe
    show(4'b0001, S7, 2);
    show(4'b0011, S1, 5);
    show(4'b0000, 7'h00, 2);
    chk("glitch_valid_a", 32'(out_valid), 32'h0);
    show(4'b0010, S2, 4);
    show(4'b0100, S3, 4);
    show(4'b1000, S4, 4);
    chk("glitch_valid_b", 32'(out_valid), 32'h0);
    show(4'b0001, S9, 4);
    chk("glitch_done_valid", 32'(out_valid), 32'h1);
    chk("glitch_done_bcd", 32'(bcd_out), 32'h4329);
    handshake();

    // Backpressure across two frames
    scan(S1, S2, S3, S4);
    chk("bp_first_bcd", 32'(bcd_out), 32'h4321);
    chk("bp_first_overrun", 32'(overrun), 32'h0);
    scan(S5, S6, S7, S8);
    chk("bp_second_valid", 32'(out_valid), 32'h1);
    chk("bp_second_bcd", 32'(bcd_out), 32'h8765);
    chk("bp_overrun", 32'(overrun), 32'h1);
    dig_sel     = 4'b0000;
    overrun_clr = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    out_ready   = 1'b0;
    chk("bp_clr_overrun", 32'(overrun), 32'h0);
    chk("bp_clr_valid", 32'(out_valid), 32'h0);

    // Handshake coinciding with frame completion
    scan(S1, S2, S3, S4);
    show(4'b0001, S5, 4);
    show(4'b0010, S6, 4);
    show(4'b0100, S7, 4);
    show(4'b1000, S8, 3);
    chk("same_pre_bcd", 32'(bcd_out), 32'h4321);
    out_ready = 1'b1;
    @(negedge clk);
    chk("same_valid", 32'(out_valid), 32'h1);
    chk("same_bcd", 32'(bcd_out), 32'h8765);
    chk("same_overrun", 32'(overrun), 32'h0);
    dig_sel = 4'b0000;
    @(negedge clk);
    out_ready = 1'b0;
    chk("same_drop_valid", 32'(out_valid), 32'h0);

    // Reset mid-frame discards the partial frame
    show(4'b0001, S1, 4);
    show(4'b0010, S2, 4);
    show(4'b0100, S3, 4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_bcd", 32'(bcd_out), 32'h0);
    chk("mid_rst_err", 32'(digit_err), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    show(4'b0000, 7'h00, 2);
    show(4'b1000, S8, 4);
    chk("post_rst_partial", 32'(out_valid), 32'h0);
    show(4'b0001, S5, 4);
    show(4'b0010, S6, 4);
    show(4'b0100, S7, 4);
    chk("post_rst_valid", 32'(out_valid), 32'h1);
    chk("post_rst_bcd", 32'(bcd_out), 32'h8765);
    chk("post_rst_err", 32'(digit_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
